// File: rtl/clken_if.sv
// Bundles the tick under test, its expected period and the monitor's status outputs.
interface clken_if #(parameter int CNT_W = 27) ();
  logic             tick;
  logic [CNT_W-1:0] expect_period;
  logic [CNT_W-1:0] period;
  // period_valid is a one-cycle pulse with no backpressure: period must be taken that cycle.
  logic             period_valid;
  logic             locked;
  logic             fault;
  logic             timeout;

  modport master (output tick, expect_period,
                  input  period, period_valid, locked, fault, timeout);
  modport slave  (input  tick, expect_period,
                  output period, period_valid, locked, fault, timeout);
endinterface

// File: rtl/clken_monitor.sv
// Measures tick-to-tick distance of a clock-enable stream, checks it against an
// expected period +/- TOL, and reports lock, sticky fault and timeout status.
module clken_monitor #(
  parameter int CNT_W  = 27,
  parameter int TOL    = 0,
  parameter int LOCK_N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  clken_if.slave     mon,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  localparam int                GOOD_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]    TOL_W     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]    ONE_W     = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              pv_q, pv_d;
  logic              fault_q, fault_d;
  logic              to_q, to_d;
  logic              to_done_q, to_done_d;

  logic [CNT_W:0]    exp_w, lo_w, hi_w;
  logic [CNT_W-1:0]  hi_bound;
  logic              good_p;

  // Tolerance window in one extra bit so exp-TOL and exp+TOL cannot wrap.
  always_comb begin
    exp_w    = {1'b0, mon.expect_period};
    lo_w     = (exp_w > TOL_W) ? (exp_w - TOL_W) : ONE_W;
    hi_w     = exp_w + TOL_W;
    hi_bound = (hi_w > {1'b0, CNT_MAX}) ? CNT_MAX : hi_w[CNT_W-1:0];
    good_p   = ({1'b0, cnt_q} >= lo_w) && (cnt_q <= hi_bound);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    good_d    = good_q;
    pv_d      = 1'b0;
    fault_d   = fault_q;
    to_d      = 1'b0;
    to_done_d = to_done_q;

    if (clr) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      period_d  = '0;
      good_d    = '0;
      fault_d   = 1'b0;
      to_done_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (mon.tick) begin
        state_d   = S_MEASURE;
        cnt_d     = CNT_ONE;
        to_done_d = 1'b0;
      end
    end else if (mon.tick) begin
      cnt_d     = CNT_ONE;
      to_done_d = 1'b0;
      period_d  = cnt_q;
      pv_d      = 1'b1;
      case (state_q)
        S_MEASURE: begin
          if (!good_p) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d = S_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        S_LOCKED: begin
          if (!good_p) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end
        S_FAULT: begin
          if (good_p) begin
            state_d = S_MEASURE;
            good_d  = '0;
          end
        end
        default: ;
      endcase
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      // to_done keeps a saturated counter sitting on hi_bound from re-firing.
      if ((cnt_q == hi_bound) && !to_done_q) begin
        to_d      = 1'b1;
        to_done_d = 1'b1;
        if (state_q == S_MEASURE) good_d = '0;
        if (state_q == S_LOCKED) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      good_q    <= '0;
      pv_q      <= 1'b0;
      fault_q   <= 1'b0;
      to_q      <= 1'b0;
      to_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      good_q    <= good_d;
      pv_q      <= pv_d;
      fault_q   <= fault_d;
      to_q      <= to_d;
      to_done_q <= to_done_d;
    end
  end

  assign mon.period       = period_q;
  assign mon.period_valid = pv_q;
  assign mon.locked       = (state_q == S_LOCKED);
  assign mon.fault        = fault_q;
  assign mon.timeout      = to_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_clken_monitor.sv
// Three monitors (TOL=0, TOL=1, CNT_W=4) share one tick stream and are checked
// every cycle against an elapsed-time model of the lock/fault rules.
module tb_clken_monitor;

  localparam int NI     = 3;
  localparam int LOCK_N = 4;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        tick;
  logic [26:0] exp_p;
  logic [1:0]  st0, st1, st2;

  int n_chk  = 0;
  int n_pass = 0;

  clken_if #(.CNT_W(27)) if0 ();
  clken_if #(.CNT_W(27)) if1 ();
  clken_if #(.CNT_W(4))  if2 ();

  assign if0.tick = tick;
  assign if1.tick = tick;
  assign if2.tick = tick;
  assign if0.expect_period = exp_p;
  assign if1.expect_period = exp_p;
  assign if2.expect_period = exp_p[3:0];

  clken_monitor #(.CNT_W(27), .TOL(0), .LOCK_N(LOCK_N)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mon(if0.slave), .dbg_state(st0));
  clken_monitor #(.CNT_W(27), .TOL(1), .LOCK_N(LOCK_N)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mon(if1.slave), .dbg_state(st1));
  clken_monitor #(.CNT_W(4), .TOL(0), .LOCK_N(LOCK_N)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mon(if2.slave), .dbg_state(st2));

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Mode codes: 0 idle, 1 measuring, 2 locked, 3 faulted.
  longint m_max[NI]  = '{134217727, 134217727, 15};
  longint m_tol[NI]  = '{0, 1, 0};
  int     m_mode[NI] = '{0, 0, 0};
  int     m_good[NI] = '{0, 0, 0};
  longint m_last[NI] = '{0, 0, 0};
  longint e_period[NI] = '{0, 0, 0};
  bit     e_pv[NI]     = '{0, 0, 0};
  bit     e_fault[NI]  = '{0, 0, 0};
  bit     e_to[NI]     = '{0, 0, 0};
  longint cyc = 0;

  task automatic model_step(int k);
    longint lo, hi, el, p, ev;
    bit ok;
    e_pv[k] = 0;
    e_to[k] = 0;
    ev = longint'(exp_p);
    if (!rst_n || clr) begin
      m_mode[k] = 0; m_good[k] = 0; e_period[k] = 0; e_fault[k] = 0;
    end else if (m_mode[k] == 0) begin
      if (tick) begin m_mode[k] = 1; m_last[k] = cyc; end
    end else begin
      lo = (ev > m_tol[k]) ? ev - m_tol[k] : 1;
      hi = ev + m_tol[k];
      if (hi > m_max[k]) hi = m_max[k];
      el = cyc - m_last[k];
      if (tick) begin
        p = (el > m_max[k]) ? m_max[k] : el;
        ok = (p >= lo) && (p <= hi);
        e_period[k] = p; e_pv[k] = 1; m_last[k] = cyc;
        case (m_mode[k])
          1: if (!ok) m_good[k] = 0;
             else begin
               m_good[k]++;
               if (m_good[k] == LOCK_N) begin m_mode[k] = 2; m_good[k] = 0; end
             end
          2: if (!ok) begin m_mode[k] = 3; e_fault[k] = 1; end
          3: if (ok) begin m_mode[k] = 1; m_good[k] = 0; end
          default: ;
        endcase
      end else if (el == hi) begin
        e_to[k] = 1;
        if (m_mode[k] == 1) m_good[k] = 0;
        if (m_mode[k] == 2) begin m_mode[k] = 3; e_fault[k] = 1; end
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) model_step(k);
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp_inst(int k, longint p, logic pv, logic lk, logic ft, logic to,
                          logic [1:0] st);
    chk($sformatf("u%0d.period", k),       p,            e_period[k]);
    chk($sformatf("u%0d.period_valid", k), longint'(pv), longint'(e_pv[k]));
    chk($sformatf("u%0d.locked", k),       longint'(lk), longint'(m_mode[k] == 2));
    chk($sformatf("u%0d.fault", k),        longint'(ft), longint'(e_fault[k]));
    chk($sformatf("u%0d.timeout", k),      longint'(to), longint'(e_to[k]));
    chk($sformatf("u%0d.state", k),        longint'(st), longint'(m_mode[k]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, longint'(if0.period), if0.period_valid, if0.locked, if0.fault, if0.timeout, st0);
    cmp_inst(1, longint'(if1.period), if1.period_valid, if1.locked, if1.fault, if1.timeout, st1);
    cmp_inst(2, longint'(if2.period), if2.period_valid, if2.locked, if2.fault, if2.timeout, st2);
  end

  // ---------------- drivers ----------------
  task automatic cyc_drv(input logic t, input logic c);
    @(negedge clk);
    #1;
    tick = t;
    clr  = c;
  endtask

  task automatic tickp(input int p);
    cyc_drv(1'b1, 1'b0);
    for (int i = 1; i < p; i++) cyc_drv(1'b0, 1'b0);
  endtask

  task automatic restart(input int e);
    exp_p = 27'(e);
    cyc_drv(1'b0, 1'b1);
    cyc_drv(1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mode, n, p;
    rst_n = 1'b0; clr = 1'b0; tick = 1'b0; exp_p = 27'd4;
    repeat (3) cyc_drv(1'b0, 1'b0);
    chk("reset.period", longint'(if0.period), 0);
    chk("reset.locked", longint'(if0.locked), 0);
    chk("reset.fault",  longint'(if0.fault),  0);
    rst_n = 1'b1;

    // Steady period 4: lock after the fifth tick.
    restart(4);
    repeat (5) tickp(4);
    chk("lock.u0.locked", longint'(if0.locked), 1);
    chk("lock.u0.period", longint'(if0.period), 4);
    chk("lock.u0.fault",  longint'(if0.fault),  0);
    chk("lock.u2.locked", longint'(if2.locked), 1);
    chk("lock.model",     longint'(m_mode[0] == 2), 1);

    // Drop one tick: timeout, fault, then recovery and re-lock.
    repeat (4) cyc_drv(1'b0, 1'b0);
    chk("drop.u0.fault",  longint'(if0.fault),  1);
    chk("drop.u0.locked", longint'(if0.locked), 0);
    repeat (6) tickp(4);
    chk("relock.u0.locked", longint'(if0.locked), 1);
    chk("relock.u0.fault",  longint'(if0.fault),  1);

    // clr together with a tick while locked.
    cyc_drv(1'b1, 1'b1);
    cyc_drv(1'b0, 1'b0);
    chk("clr.u0.state",  longint'(st0), 0);
    chk("clr.u0.pv",     longint'(if0.period_valid), 0);
    chk("clr.u0.period", longint'(if0.period), 0);
    chk("clr.u0.fault",  longint'(if0.fault), 0);

    // Tolerance 1: periods 3,5,4,5 lock u1 only; a period of 6 faults it.
    restart(4);
    tickp(3); tickp(5); tickp(4); tickp(5);
    cyc_drv(1'b1, 1'b0);
    cyc_drv(1'b0, 1'b0);
    chk("tol.u1.locked", longint'(if1.locked), 1);
    chk("tol.u0.locked", longint'(if0.locked), 0);
    repeat (4) cyc_drv(1'b0, 1'b0);
    cyc_drv(1'b1, 1'b0);
    cyc_drv(1'b0, 1'b0);
    chk("tol.u1.period", longint'(if1.period), 6);
    chk("tol.u1.fault",  longint'(if1.fault),  1);

    // Tick held high.
    restart(1);
    repeat (10) cyc_drv(1'b1, 1'b0);
    cyc_drv(1'b0, 1'b0);
    chk("high1.u0.locked", longint'(if0.locked), 1);
    chk("high1.u0.period", longint'(if0.period), 1);
    restart(4);
    repeat (10) cyc_drv(1'b1, 1'b0);
    cyc_drv(1'b0, 1'b0);
    chk("high4.u0.locked", longint'(if0.locked), 0);
    chk("high4.u0.fault",  longint'(if0.fault),  0);

    // Saturation on the 4-bit instance.
    restart(15);
    cyc_drv(1'b1, 1'b0);
    repeat (40) cyc_drv(1'b0, 1'b0);
    cyc_drv(1'b1, 1'b0);
    cyc_drv(1'b0, 1'b0);
    chk("sat.u2.period", longint'(if2.period), 15);
    chk("sat.u2.pv",     longint'(if2.period_valid), 1);
    chk("sat.u0.period", longint'(if0.period), 41);

    // Asynchronous reset mid-period while locked.
    restart(4);
    repeat (6) tickp(4);
    cyc_drv(1'b1, 1'b0);
    cyc_drv(1'b0, 1'b0);
    chk("arst.pre.locked", longint'(if0.locked), 1);
    rst_n = 1'b0;
    #1;
    chk("arst.u0.locked", longint'(if0.locked), 0);
    chk("arst.u0.period", longint'(if0.period), 0);
    chk("arst.u1.locked", longint'(if1.locked), 0);
    repeat (2) cyc_drv(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (6) tickp(4);
    chk("arst.relock", longint'(if0.locked), 1);

    // Randomized traffic.
    for (int b = 0; b < 60; b++) begin
      restart($urandom_range(1, 15));
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          n = $urandom_range(6, 14);
          for (int j = 0; j < n; j++) begin
            p = int'(exp_p) + $urandom_range(0, 2) - 1;
            if (p < 1) p = 1;
            if ($urandom_range(0, 7) == 0) p = p * 2;
            tickp(p);
          end
        end
        1: begin
          for (int j = 0; j < 60; j++)
            cyc_drv($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
        end
        2: begin
          for (int j = 0; j < 3; j++) begin
            repeat ($urandom_range(5, 15)) cyc_drv(1'b1, 1'b0);
            repeat ($urandom_range(1, 20)) cyc_drv(1'b0, 1'b0);
          end
        end
        default: begin
          repeat ($urandom_range(6, 10)) tickp(int'(exp_p));
          rst_n = 1'b0;
          repeat ($urandom_range(1, 3)) cyc_drv($urandom_range(0, 1) == 1, 1'b0);
          rst_n = 1'b1;
          repeat ($urandom_range(5, 8)) tickp(int'(exp_p));
        end
      endcase
    end

    cyc_drv(1'b0, 1'b0);
    cyc_drv(1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
